// File: rtl/multipath_spy_delay_line.sv
// Multi-channel register delay line with a sequential trojan model that
// inverts masked channels once its trigger has held for TRIG_COUNT cycles.
module multipath_spy_delay_line #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned TRIG_COUNT  = 3,
    parameter int unsigned FIRE_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             ht_in1,
    input  logic             ht_in2,
    input  logic [WIDTH-1:0] ht_mask,
    input  logic             ht_clear,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             ht_active,
    output logic [CNT_W-1:0] fire_count
);

    localparam int unsigned TCW     = (TRIG_COUNT > 1) ? $clog2(TRIG_COUNT) : 1;
    localparam int unsigned FCW     = (FIRE_CYCLES > 1) ? $clog2(FIRE_CYCLES) : 1;
    localparam int unsigned TC_LAST = TRIG_COUNT - 1;
    localparam int unsigned FC_LAST = (FIRE_CYCLES > 0) ? FIRE_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRE,
        ST_COOLDOWN
    } state_t;

    state_t           state_q, state_d;
    logic [TCW-1:0]   trig_cnt_q, trig_cnt_d;
    logic [FCW-1:0]   fire_cnt_q, fire_cnt_d;
    logic [CNT_W-1:0] fire_count_q, fire_count_d;
    logic             ht_active_q, ht_active_d;
    logic             trig;

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    assign trig = ht_in1 & ht_in2;

    // Trojan state and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            trig_cnt_q   <= '0;
            fire_cnt_q   <= '0;
            fire_count_q <= '0;
            ht_active_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            trig_cnt_q   <= trig_cnt_d;
            fire_cnt_q   <= fire_cnt_d;
            fire_count_q <= fire_count_d;
            ht_active_q  <= ht_active_d;
        end
    end

    // Next state; a clear wins over a simultaneous arming edge
    always_comb begin
        state_d      = state_q;
        trig_cnt_d   = trig_cnt_q;
        fire_cnt_d   = fire_cnt_q;
        fire_count_d = fire_count_q;
        if (ht_clear) begin
            state_d    = ST_IDLE;
            trig_cnt_d = '0;
            fire_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    fire_cnt_d = '0;
                    if (trig) begin
                        if (trig_cnt_q == TCW'(TC_LAST)) begin
                            state_d    = ST_FIRE;
                            trig_cnt_d = '0;
                            if (fire_count_q != '1) begin
                                fire_count_d = fire_count_q + CNT_W'(1);
                            end
                        end else begin
                            trig_cnt_d = trig_cnt_q + TCW'(1);
                        end
                    end else begin
                        trig_cnt_d = '0;
                    end
                end
                ST_FIRE: begin
                    if (FIRE_CYCLES != 0) begin
                        if (fire_cnt_q == FCW'(FC_LAST)) begin
                            state_d    = ST_COOLDOWN;
                            fire_cnt_d = '0;
                        end else begin
                            fire_cnt_d = fire_cnt_q + FCW'(1);
                        end
                    end
                end
                ST_COOLDOWN: begin
                    if (!trig) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    trig_cnt_d = '0;
                    fire_cnt_d = '0;
                end
            endcase
        end
        ht_active_d = (state_d == ST_FIRE);
    end

    // Delay line: stage 0 applies the payload, later stages just shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
            valid_q <= '0;
        end else begin
            data_q[0]  <= din ^ (ht_mask & {WIDTH{ht_active_q}});
            valid_q[0] <= din_valid;
            for (int k = 1; k < DEPTH; k++) begin
                data_q[k]  <= data_q[k-1];
                valid_q[k] <= valid_q[k-1];
            end
        end
    end

    assign dout       = data_q[DEPTH-1];
    assign dout_valid = valid_q[DEPTH-1];
    assign ht_active  = ht_active_q;
    assign fire_count = fire_count_q;

endmodule

// File: tb/tb_multipath_spy_delay_line.sv
// Bench for multipath_spy_delay_line: a bounded-window build and a sticky
// build share one stimulus stream and are checked against a behavioural model.
module tb_multipath_spy_delay_line;

    localparam int unsigned W     = 4;
    localparam int unsigned D     = 8;
    localparam int unsigned TC    = 3;
    localparam int unsigned CW    = 8;
    localparam int unsigned NINST = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         ht_in1 = 1'b0;
    logic         ht_in2 = 1'b0;
    logic [W-1:0] ht_mask = '0;
    logic         ht_clear = 1'b0;

    logic [W-1:0]  dout_a, dout_b;
    logic          dout_valid_a, dout_valid_b;
    logic          ht_active_a, ht_active_b;
    logic [CW-1:0] fire_count_a, fire_count_b;

    multipath_spy_delay_line #(
        .WIDTH(W), .DEPTH(D), .TRIG_COUNT(TC), .FIRE_CYCLES(4), .CNT_W(CW)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .ht_in1(ht_in1), .ht_in2(ht_in2), .ht_mask(ht_mask), .ht_clear(ht_clear),
        .dout(dout_a), .dout_valid(dout_valid_a),
        .ht_active(ht_active_a), .fire_count(fire_count_a)
    );

    multipath_spy_delay_line #(
        .WIDTH(W), .DEPTH(D), .TRIG_COUNT(TC), .FIRE_CYCLES(0), .CNT_W(CW)
    ) u_sticky (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .ht_in1(ht_in1), .ht_in2(ht_in2), .ht_mask(ht_mask), .ht_clear(ht_clear),
        .dout(dout_b), .dout_valid(dout_valid_b),
        .ht_active(ht_active_b), .fire_count(fire_count_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Behavioural model: 0 waiting for a trigger run, 1 payload on, 2 waiting for trig low
    int           fire_len [NINST] = '{4, 0};
    int           m_phase  [NINST];
    int           m_run    [NINST];
    int           m_left   [NINST];
    int           m_fires  [NINST];
    logic [W:0]   pq0 [$];
    logic [W:0]   pq1 [$];

    task automatic model_reset();
        for (int i = 0; i < NINST; i++) begin
            m_phase[i] = 0; m_run[i] = 0; m_left[i] = 0; m_fires[i] = 0;
        end
        pq0.delete(); pq1.delete();
        for (int k = 0; k < D; k++) begin
            pq0.push_back('0); pq1.push_back('0);
        end
    endtask

    task automatic model_edge();
        logic       trig;
        logic [W:0] smp;
        trig = ht_in1 & ht_in2;
        for (int i = 0; i < NINST; i++) begin
            smp = {din_valid, din ^ ((m_phase[i] == 1) ? ht_mask : W'(0))};
            if (i == 0) begin pq0.push_back(smp); void'(pq0.pop_front()); end
            else        begin pq1.push_back(smp); void'(pq1.pop_front()); end
            if (ht_clear) begin
                m_phase[i] = 0; m_run[i] = 0;
            end else if (m_phase[i] == 0) begin
                m_run[i] = trig ? m_run[i] + 1 : 0;
                if (m_run[i] == TC) begin
                    m_phase[i] = 1; m_run[i] = 0; m_left[i] = fire_len[i];
                    if (m_fires[i] < 255) m_fires[i]++;
                end
            end else if (m_phase[i] == 1) begin
                if (fire_len[i] > 0) begin
                    m_left[i]--;
                    if (m_left[i] == 0) m_phase[i] = 2;
                end
            end else if (!trig) begin
                m_phase[i] = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("dout_a",       32'(dout_a),       32'(pq0[0][W-1:0]));
        check("valid_a",      32'(dout_valid_a), 32'(pq0[0][W]));
        check("active_a",     32'(ht_active_a),  32'(m_phase[0] == 1));
        check("fire_count_a", 32'(fire_count_a), 32'(m_fires[0]));
        check("dout_b",       32'(dout_b),       32'(pq1[0][W-1:0]));
        check("valid_b",      32'(dout_valid_b), 32'(pq1[0][W]));
        check("active_b",     32'(ht_active_b),  32'(m_phase[1] == 1));
        check("fire_count_b", 32'(fire_count_b), 32'(m_fires[1]));
    endtask

    // One clock edge: model follows the edge, outputs sampled 1 time unit later
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic set_trig(input logic t);
        ht_in1 = t; ht_in2 = t;
    endtask

    task automatic run_pattern(input logic [31:0] pat, input int len);
        for (int k = len - 1; k >= 0; k--) begin
            set_trig(pat[k]);
            step();
        end
        set_trig(1'b0);
    endtask

    initial begin
        model_reset();
        #12;
        check("reset_dout",  32'(dout_a),       32'(0));
        check("reset_valid", 32'(dout_valid_a), 32'(0));
        check("reset_fc",    32'(fire_count_b), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Clean pass-through of a counting sequence
        din_valid = 1'b1;
        for (int k = 0; k < 24; k++) begin
            din = W'(k);
            step();
        end

        // Single fire with constant zero data
        din = '0; ht_mask = 4'b0101;
        run_pattern(32'b111, 3);
        for (int k = 0; k < 16; k++) step();
        check("one_fire_count", 32'(fire_count_a), 32'(1));
        ht_clear = 1'b1; step(); ht_clear = 1'b0;
        check("sticky_cleared", 32'(ht_active_b), 32'(0));

        // Glitch restarts the count
        run_pattern(32'b110111, 6);
        for (int k = 0; k < 12; k++) step();
        check("glitch_fire_count", 32'(fire_count_a), 32'(2));

        // Long trigger fires once, re-arm needs a low edge and a fresh run
        run_pattern(32'hFFFFF, 20);
        step();
        check("long_trig_count", 32'(fire_count_a), 32'(3));
        run_pattern(32'b111, 3);
        for (int k = 0; k < 6; k++) step();
        check("rearm_count", 32'(fire_count_a), 32'(4));

        // Sticky build holds for 50 cycles, then clears
        for (int k = 0; k < 50; k++) begin
            din = W'($urandom);
            step();
        end
        check("sticky_hold", 32'(ht_active_b), 32'(1));
        ht_clear = 1'b1; step(); ht_clear = 1'b0;
        check("sticky_clear", 32'(ht_active_b), 32'(0));

        // Clear on the arming edge suppresses the fire
        run_pattern(32'b11, 2);
        set_trig(1'b1); ht_clear = 1'b1; step(); ht_clear = 1'b0; set_trig(1'b0);
        step();
        check("clear_arm_active", 32'(ht_active_a), 32'(0));
        check("clear_arm_count",  32'(fire_count_a), 32'(4));

        // Asynchronous reset in the middle of a fire window
        run_pattern(32'b111, 3);
        step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_dout",   32'(dout_a),       32'(0));
        check("async_rst_valid",  32'(dout_valid_a), 32'(0));
        check("async_rst_active", 32'(ht_active_a),  32'(0));
        check("async_rst_fc",     32'(fire_count_a), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic
        for (int k = 0; k < 3000; k++) begin
            din       = W'($urandom);
            din_valid = ($urandom_range(0, 3) != 0);
            ht_mask   = W'($urandom);
            ht_in1    = ($urandom_range(0, 9) < 8);
            ht_in2    = ($urandom_range(0, 9) < 8);
            ht_clear  = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
